// File: rtl/instr_mem_fetch_pkg.sv
// Shared types and default widths for the IF-stage fetch block.
// The IF/ID register uses the same width defaults.
package instr_mem_fetch_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, registered read with enable.
// Array contents survive reset; only the read register clears.
module imem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_mem_fetch.sv
// IF stage: loadable instruction memory with fetch PC,
// stall, branch redirect and sticky out-of-range fault.
module instr_mem_fetch
    import instr_mem_fetch_pkg::*;
#(
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          DEPTH    = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    output logic              busy,
    output logic              fault
);

    localparam int                IDX_W      = idx_w(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic              pc_ok;
    logic              load_ok;
    logic              wr_en;
    logic              rd_en;

    // Extra MSB keeps DEPTH == 2**ADDR_W representable.
    assign pc_ok   = {1'b0, pc} < DEPTH_L;
    assign load_ok = {1'b0, load_addr} < DEPTH_L;

    assign wr_en = (state == ST_LOAD) && load_en && load_ok;
    assign rd_en = (state == ST_RUN) && !branch_en && !stall && pc_ok;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (load_addr[IDX_W-1:0]),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (pc[IDX_W-1:0]),
        .rd_data (instruction)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_LOAD;
            pc          <= RESET_PC_L;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (start) begin
                        state <= ST_RUN;
                        pc    <= RESET_PC_L;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (branch_en) begin
                        // Squash the fetch already in flight.
                        pc          <= branch_target;
                        instr_valid <= 1'b0;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (!pc_ok) begin
                        state       <= ST_HALT;
                        fault       <= 1'b1;
                        instr_valid <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 1'b1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Scoreboard bench for instr_mem_fetch: directed loads,
// run, stall, branch, reset mid-run and out-of-range fault.
module tb_instr_mem_fetch;

    logic       clk = 1'b0;
    logic       reset, load_en, start, stall, branch_en;
    logic [7:0] load_addr, load_data, branch_target;
    logic [7:0] instruction, pc_out;
    logic       instr_valid, busy, fault;

    logic       reset2, load_en2, start2;
    logic [7:0] load_addr2, load_data2;
    logic       nostall, nobranch;
    logic [7:0] notarget;
    logic [7:0] instruction2, pc_out2;
    logic       instr_valid2, busy2, fault2;

    int errors = 0;
    int checks = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    instr_mem_fetch #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(16), .RESET_PC(0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .start         (start),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .busy          (busy),
        .fault         (fault)
    );

    instr_mem_fetch #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(16), .RESET_PC(14)
    ) dut2 (
        .clk           (clk),
        .reset         (reset2),
        .load_en       (load_en2),
        .load_addr     (load_addr2),
        .load_data     (load_data2),
        .start         (start2),
        .stall         (nostall),
        .branch_en     (nobranch),
        .branch_target (notarget),
        .instruction   (instruction2),
        .pc_out        (pc_out2),
        .instr_valid   (instr_valid2),
        .busy          (busy2),
        .fault         (fault2)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push0(input logic [7:0] ins, input logic [7:0] pc);
        q0.push_back({ins, pc});
    endtask

    task automatic load0(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step(1);
        load_en = 1'b0;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_instr"}, 32'(instruction), 32'h0);
        chk({tag, "_pc_out"}, 32'(pc_out), 32'h0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_fault"}, 32'(fault), 32'h0);
    endtask

    // Monitor: every live fetch must match the head of its queue.
    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon0: got %h/%h expected no output",
                         instruction, pc_out);
            end else begin
                chk("mon0", 32'({instruction, pc_out}), 32'(q0.pop_front()));
            end
        end
        if (instr_valid2 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL mon1: got %h/%h expected no output",
                         instruction2, pc_out2);
            end else begin
                chk("mon1", 32'({instruction2, pc_out2}), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; load_en = 1'b0; start = 1'b0; stall = 1'b0;
        branch_en = 1'b0; load_addr = '0; load_data = '0; branch_target = '0;
        reset2 = 1'b1; load_en2 = 1'b0; start2 = 1'b0;
        load_addr2 = '0; load_data2 = '0;
        nostall = 1'b0; nobranch = 1'b0; notarget = '0;
        step(2);
        chk_reset0("rst");
        reset = 1'b0; reset2 = 1'b0;

        load0(8'd0, 8'h11); load0(8'd1, 8'h22); load0(8'd2, 8'h33);
        load0(8'd3, 8'h44); load0(8'd4, 8'h55); load0(8'd5, 8'h66);
        load0(8'd6, 8'h77);
        load0(8'd16, 8'hFF);
        // Last write coincides with start.
        start = 1'b1;
        load0(8'd7, 8'h88);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_valid", 32'(instr_valid), 32'h0);

        // Run A: writes during RUN must be ignored.
        load_en = 1'b1; load_addr = 8'd1; load_data = 8'hEE;
        push0(8'h11, 8'd0); push0(8'h22, 8'd1); push0(8'h33, 8'd2);
        push0(8'h44, 8'd3); push0(8'h55, 8'd4);
        step(5);
        load_en = 1'b0; reset = 1'b1;
        step(1);
        chk_reset0("midrun");
        reset = 1'b0;

        // Run B: restart, stall three cycles at pc_out=1.
        start = 1'b1; step(1); start = 1'b0;
        push0(8'h11, 8'd0);
        push0(8'h22, 8'd1); push0(8'h22, 8'd1);
        push0(8'h22, 8'd1); push0(8'h22, 8'd1);
        push0(8'h33, 8'd2);
        step(2);
        stall = 1'b1; step(3); stall = 1'b0;
        step(1);
        reset = 1'b1; step(1); reset = 1'b0;

        // Run C: branch, then branch together with stall.
        start = 1'b1; step(1); start = 1'b0;
        push0(8'h11, 8'd0); push0(8'h44, 8'd3);
        push0(8'h55, 8'd4); push0(8'h44, 8'd3);
        step(1);
        branch_en = 1'b1; branch_target = 8'd3; step(1); branch_en = 1'b0;
        chk("br_squash", 32'(instr_valid), 32'h0);
        step(2);
        branch_en = 1'b1; stall = 1'b1; step(1);
        branch_en = 1'b0; stall = 1'b0;
        chk("br_stall_squash", 32'(instr_valid), 32'h0);
        step(1);
        reset = 1'b1; step(1); reset = 1'b0;

        // Fault run on the RESET_PC=14 instance.
        load_en2 = 1'b1;
        load_addr2 = 8'd14; load_data2 = 8'hA1; step(1);
        load_addr2 = 8'd15; load_data2 = 8'hB2; step(1);
        load_en2 = 1'b0;
        start2 = 1'b1; step(1); start2 = 1'b0;
        q1.push_back({8'hA1, 8'd14});
        q1.push_back({8'hB2, 8'd15});
        step(3);
        chk("flt_fault", 32'(fault2), 32'h1);
        chk("flt_busy", 32'(busy2), 32'h0);
        chk("flt_valid", 32'(instr_valid2), 32'h0);
        start2 = 1'b1; step(1); start2 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(1);
            chk("halt_fault", 32'(fault2), 32'h1);
            chk("halt_busy", 32'(busy2), 32'h0);
            chk("halt_valid", 32'(instr_valid2), 32'h0);
            chk("halt_hold", 32'({instruction2, pc_out2}), 32'h0000B20F);
        end

        step(2);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
